// File: rtl/capture_pkg.sv
// Shared constants for the logic-analyser capture controller: FSM state
// encoding and the channel count.
package capture_pkg;

    // Number of probe channels sampled per strobe.
    localparam int CH_W = 4;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/capture_ctrl_trig_detect.sv
// Edge trigger detector: keeps the previous sample and flags a sample on
// which any enabled channel shows an edge of the selected polarity. An
// all-zero mask fires unconditionally so capture proceeds immediately.
module trig_detect
    import capture_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_en_i,
    input  logic [CH_W-1:0] ch_i,
    input  logic [CH_W-1:0] mask_i,
    input  logic [CH_W-1:0] pol_i,
    output logic            fire_o
);

    logic [CH_W-1:0] prev_q;
    logic [CH_W-1:0] rise;
    logic [CH_W-1:0] fall;

    // Previous sample, advanced only on accepted capture samples.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register sees pre-edge values regardless of statement order.
        if (reset) begin
            prev_q <= '0;
        end else if (sample_en_i) begin
            prev_q <= ch_i;
        end
    end

    assign rise   = ~prev_q &  ch_i;
    assign fall   =  prev_q & ~ch_i;
    assign fire_o = (mask_i == '0) || (|(mask_i & ((pol_i & rise) | (~pol_i & fall))));

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller: fills a circular sample buffer with PRE_DEPTH
// pre-trigger samples, waits for an edge trigger, then fills the rest of
// the buffer and holds it until the reader acknowledges.
// Optional feature: define CAPTURE_CTRL_AUTO_TRIG_EN to force a trigger
// after 2^ADDR_W trigger-less WAIT samples (reported on auto_trig).
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int PRE_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              smpl_en,
    input  logic              arm,
    input  logic [CH_W-1:0]   ch_in,
    input  logic [CH_W-1:0]   trig_mask,
    input  logic [CH_W-1:0]   trig_pol,
    input  logic              rd_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CH_W-1:0]   wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              auto_trig
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int POST_N = DEPTH - PRE_DEPTH - 1;
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_DEPTH - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_N - 1);

    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              wr_en_q,     wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [CH_W-1:0]   wr_data_q,   wr_data_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              capturing;
    logic              sample_en;
    logic              trig_fire;

`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
    localparam logic [CNT_W-1:0] AUTO_LIM = CNT_W'(DEPTH);
    logic auto_q, auto_d;
    logic auto_fire;
    assign auto_fire = (cnt_q == AUTO_LIM);
`endif

    assign capturing = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
    assign sample_en = smpl_en && capturing;

    trig_detect u_trig_detect (
        .clk         (clk),
        .reset       (reset),
        .sample_en_i (sample_en),
        .ch_i        (ch_in),
        .mask_i      (trig_mask),
        .pol_i       (trig_pol),
        .fire_o      (trig_fire)
    );

    // Next-state, counter and write-port logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        trig_addr_d = trig_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
        auto_d      = auto_q;
`endif

        // Every accepted sample becomes exactly one buffer write.
        if (sample_en) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = ch_in;
            addr_d    = addr_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_PRE;
                    addr_d  = '0;
                    cnt_d   = '0;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
                    auto_d  = 1'b0;
`endif
                end
            end
            ST_PRE: begin
                if (smpl_en) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (smpl_en) begin
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
                    if (trig_fire || auto_fire) begin
                        state_d     = ST_POST;
                        trig_addr_d = addr_q;
                        cnt_d       = '0;
                        auto_d      = !trig_fire;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    if (trig_fire) begin
                        state_d     = ST_POST;
                        trig_addr_d = addr_q;
                        cnt_d       = '0;
                    end
`endif
                end
            end
            ST_POST: begin
                if (smpl_en) begin
                    if (cnt_q == POST_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (rd_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            trig_addr_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
            auto_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            trig_addr_q <= trig_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
            auto_q      <= auto_d;
`endif
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign trig_addr = trig_addr_q;
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
    assign auto_trig = auto_q;
`else
    assign auto_trig = 1'b0;
`endif

endmodule
